// File: rtl/interleaved_fifo_ctrl.sv
// Round-robin sequencer that stripes a stream across NUM_BANKS small FIFOs
// and drains them in the same order, presenting one in-order aggregate FIFO.
module interleaved_fifo_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_BANKS  = 4,
  parameter int unsigned BANK_DEPTH = 2
) (
  input  logic                                       clk,
  input  logic                                       rstn,
  input  logic [DATA_WIDTH-1:0]                      in_data,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  output logic [DATA_WIDTH-1:0]                      out_data,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  input  logic                                       clear,
  output logic [$clog2(NUM_BANKS*BANK_DEPTH):0]      count,
  output logic                                       full,
  output logic                                       empty,
  output logic [DATA_WIDTH-1:0]                      bank_in_data,
  output logic [NUM_BANKS-1:0]                       bank_in_valid,
  input  logic [NUM_BANKS-1:0]                       bank_in_ready,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0]            bank_out_data,
  input  logic [NUM_BANKS-1:0]                       bank_out_valid,
  output logic [NUM_BANKS-1:0]                       bank_out_ready,
  output logic                                       bank_clear
);

  localparam int unsigned CAP = NUM_BANKS * BANK_DEPTH;
  localparam int unsigned CW  = $clog2(CAP) + 1;
  localparam int unsigned PW  = $clog2(NUM_BANKS);

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t        state;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          run;
  logic          push;
  logic          pop;

  // Flags come straight off the count register so they never depend on inputs.
  assign full         = (count == CW'(CAP));
  assign empty        = (count == CW'(0));
  assign bank_in_data = in_data;

  // Handshake steering: only the bank under each pointer is ever addressed.
  always_comb begin
    run            = (state == RUN) && !clear;
    in_ready       = run && bank_in_ready[wr_ptr] && !full;
    out_valid      = run && bank_out_valid[rd_ptr] && !empty;
    push           = in_valid && in_ready;
    pop            = out_valid && out_ready;
    bank_in_valid  = '0;
    bank_out_ready = '0;
    if (push) bank_in_valid[wr_ptr] = 1'b1;
    if (pop)  bank_out_ready[rd_ptr] = 1'b1;
    bank_clear     = (state != RUN);
    out_data       = '0;
    for (int unsigned k = 0; k < NUM_BANKS; k++) begin
      if (rd_ptr == PW'(k)) out_data = bank_out_data[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= INIT;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      case (state)
        INIT: state <= RUN;
        RUN: begin
          if (clear) state <= FLUSH;
          // Power-of-two bank count lets the pointer wrap naturally.
          if (push) wr_ptr <= wr_ptr + PW'(1);
          if (pop)  rd_ptr <= rd_ptr + PW'(1);
          if (push && !pop)      count <= count + CW'(1);
          else if (pop && !push) count <= count - CW'(1);
        end
        FLUSH: begin
          wr_ptr <= '0;
          rd_ptr <= '0;
          count  <= '0;
          if (!clear) state <= RUN;
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule
